// File: rtl/seg_display_ctrl_pkg.sv
// Shared types and constants for the seven-segment display sequencer.
package seg_disp_pkg;

    localparam int DIGITS = 8;
    localparam int BCD_W  = 40;
    localparam int BIN_W  = 32;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

    localparam logic [2:0] SEL_HEX    = 3'd0;
    localparam logic [2:0] SEL_ALL    = 3'd1;
    localparam logic [2:0] SEL_BRANCH = 3'd2;
    localparam logic [2:0] SEL_JUMP   = 3'd3;
    localparam logic [2:0] SEL_SUC    = 3'd4;

    // Active-low segment patterns for hex digits 0-F, dp bit held off.
    localparam logic [7:0] SEG_CODE [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic is_dec(input logic [2:0] s);
        return (s >= SEL_ALL) && (s <= SEL_SUC);
    endfunction

endpackage

// File: rtl/seg_display_ctrl_bcd_iter.sv
// Iterative double-dabble: start loads the binary word, each step does one adjust+shift.
// done_o flags the 32nd step; bin_o holds the unshifted word when no steps are taken.
module seg_bcd_iter
    import seg_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [BIN_W-1:0] bin_o,
    output logic [BCD_W-1:0] bcd_o,
    output logic             done_o
);
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [4:0]       cnt_q, cnt_d;

    always_comb begin
        adj   = bcd_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bin_o  = bin_q;
    assign bcd_o  = bcd_q;
    assign done_o = step_i && (cnt_q == 5'd31);

endmodule

// File: rtl/seg_display_ctrl.sv
// Display sequencer: picks a source, builds hex or decimal digits, double-buffers and scans 8 digits.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits in decimal mode.
module seg_display_ctrl
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int REFRESH_DIV = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power,
    input  logic [2:0]  sel,
    input  logic [31:0] SyscallOut,
    input  logic [31:0] T_all,
    input  logic [31:0] T_branch,
    input  logic [31:0] T_suc,
    input  logic [31:0] T_jump,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        busy,
    output logic        ovf
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] REFR_LAST = RW'(REFRESH_DIV - 1);

    state_t           state_q;
    logic [2:0]       sel_q;
    logic             pend_q, busy_q, ovf_q;
    logic [BIN_W-1:0] digit_q;
    logic [BIN_W-1:0] src, work_bin;
    logic [BCD_W-1:0] bcd;
    logic             conv_done, trig, cur_blank;
    logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
    logic [RW-1:0]    refr_cnt_q, refr_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       seg_q, an_q;
    logic [3:0]       cur_dig;

    always_comb begin
        case (sel)
            SEL_ALL:    src = T_all;
            SEL_BRANCH: src = T_branch;
            SEL_JUMP:   src = T_jump;
            SEL_SUC:    src = T_suc;
            default:    src = SyscallOut;
        endcase
    end

    // During LOAD sel is being captured into sel_q, so a mismatch there is not a new request.
    assign trig = (refr_cnt_q == REFR_LAST) || ((state_q != LOAD) && (sel != sel_q));

    seg_bcd_iter u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (state_q == LOAD),
        .step_i  (state_q == CONV),
        .bin_i   (src),
        .bin_o   (work_bin),
        .bcd_o   (bcd),
        .done_o  (conv_done)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    always_comb begin
        logic seen;
        seen    = 1'b0;
        blank_d = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen       = seen | (bcd[4*i +: 4] != 4'd0);
            blank_d[i] = ~seen;
        end
    end

    assign cur_blank = blank_q[idx_q];
`else
    assign cur_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_HEX;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            digit_q <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig || pend_q) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    sel_q   <= sel;
                    state_q <= is_dec(sel) ? CONV : DONE;
                    pend_q  <= pend_q | trig;
                end
                CONV: begin
                    if (conv_done)
                        state_q <= DONE;
                    pend_q <= pend_q | trig;
                end
                default: begin
                    if (is_dec(sel_q)) begin
                        digit_q <= bcd[BIN_W-1:0];
                        ovf_q   <= |bcd[BCD_W-1:BIN_W];
`ifdef LEADING_ZERO_BLANK_EN
                        blank_q <= blank_d;
`endif
                    end else begin
                        digit_q <= work_bin;
                        ovf_q   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                        blank_q <= '0;
`endif
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    pend_q  <= pend_q | trig;
                end
            endcase
        end
    end

    always_comb begin
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        idx_d      = (scan_cnt_q == SCAN_LAST) ? idx_q + 3'd1 : idx_q;
        refr_cnt_d = (refr_cnt_q == REFR_LAST) ? '0 : refr_cnt_q + 1'b1;
    end

    assign cur_dig = digit_q[4*idx_q +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            refr_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= 8'hC0;
            an_q       <= 8'hFE;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            refr_cnt_q <= refr_cnt_d;
            idx_q      <= idx_d;
            if (!power) begin
                seg_q <= 8'hFF;
                an_q  <= 8'hFF;
            end else begin
                seg_q <= SEG_CODE[cur_dig];
                an_q  <= cur_blank ? 8'hFF : ~(8'h01 << idx_q);
            end
        end
    end

    assign SEG  = seg_q;
    assign AN   = an_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with short scan/refresh dividers.
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, power;
    logic [2:0]  sel;
    logic [31:0] SyscallOut, T_all, T_branch, T_suc, T_jump;
    logic [7:0]  SEG, AN;
    logic        busy, ovf;

    int errors = 0;
    int checks = 0;
    int n;

    logic [7:0] code [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_display_ctrl #(.SCAN_DIV(4), .REFRESH_DIV(64)) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .sel(sel),
        .SyscallOut(SyscallOut), .T_all(T_all), .T_branch(T_branch),
        .T_suc(T_suc), .T_jump(T_jump),
        .SEG(SEG), .AN(AN), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && busy !== 1'b0; c++) @(negedge clk);
    endtask

    task automatic wait_rise(input string tag);
        @(negedge clk);
        for (int c = 0; c < 200 && busy !== 1'b1; c++) @(negedge clk);
        chk({tag, " busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic count_high(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_scan(input string tag, input logic [31:0] digs, input logic [7:0] mask);
        logic [7:0] seen;
        logic [7:0] segs [8];
        logic [7:0] onehot;
        int bad, prev, idx;
        bit order_bad;
        seen = '0; bad = 0; prev = -1; order_bad = 0;
        for (int i = 0; i < 8; i++) segs[i] = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (AN !== 8'hFF) begin
                idx = -1;
                for (int i = 0; i < 8; i++) begin
                    onehot = ~(8'h01 << i);
                    if (AN === onehot) idx = i;
                end
                if (idx < 0) bad++;
                else begin
                    seen[idx] = 1'b1;
                    segs[idx] = SEG;
                    if (prev >= 0 && idx != prev && idx != (prev + 1) % 8) order_bad = 1'b1;
                    prev = idx;
                end
            end
        end
        chk({tag, " an_onehot"}, 32'(bad), 32'd0);
        chk({tag, " slots"}, 32'(seen), 32'(mask));
        if (mask == 8'hFF) chk({tag, " order"}, 32'(order_bad), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) chk($sformatf("%s seg%0d", tag, i), 32'(segs[i]), 32'(code[digs[4*i +: 4]]));
        end
    endtask

    initial begin
        rst_n = 1'b0; power = 1'b1; sel = 3'd0;
        SyscallOut = '0; T_all = '0; T_branch = '0; T_suc = '0; T_jump = '0;
        repeat (2) @(negedge clk);
        chk("reset SEG", 32'(SEG), 32'hC0);
        chk("reset AN", 32'(AN), 32'hFE);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // Hex: sel unchanged, so the periodic refresh performs the load.
        SyscallOut = 32'h1234ABCD;
        wait_rise("hex");
        count_high(n);
        chk("hex busy_len", 32'(n), 32'd2);
        chk("hex digits", dut.digit_q, 32'h1234ABCD);
        chk("hex ovf", 32'(ovf), 32'd0);
        check_scan("hex", 32'h1234ABCD, 8'hFF);

        wait_idle();
        T_all = 32'd98765432; sel = 3'd1;
        wait_rise("dec");
        count_high(n);
        chk("dec busy_len", 32'(n), 32'd34);
        chk("dec digits", dut.digit_q, 32'h98765432);
        chk("dec ovf", 32'(ovf), 32'd0);
        check_scan("dec", 32'h98765432, 8'hFF);

        wait_idle();
        T_branch = 32'd123456789; sel = 3'd2;
        wait_rise("ovf");
        count_high(n);
        chk("ovf busy_len", 32'(n), 32'd34);
        chk("ovf digits", dut.digit_q, 32'h23456789);
        chk("ovf set", 32'(ovf), 32'd1);
        wait_idle();
        sel = 3'd0;
        wait_rise("ovfclr");
        count_high(n);
        chk("ovfclr busy_len", 32'(n), 32'd2);
        chk("ovfclr ovf", 32'(ovf), 32'd0);

        // Select change mid-conversion: old value commits, then a reload follows.
        wait_idle();
        T_jump = 32'd4000000123; sel = 3'd1;
        wait_rise("mid");
        repeat (10) @(negedge clk);
        sel = 3'd3;
        count_high(n);
        chk("mid first_len", 32'(n + 10), 32'd34);
        chk("mid first_digits", dut.digit_q, 32'h98765432);
        chk("mid gap_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("mid reload_busy", 32'(busy), 32'd1);
        count_high(n);
        chk("mid second_len", 32'(n), 32'd34);
        chk("mid second_digits", dut.digit_q, 32'h00000123);
        chk("mid second_ovf", 32'(ovf), 32'd1);

        wait_idle();
        T_suc = 32'd42; sel = 3'd4;
        wait_rise("rst");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst SEG", 32'(SEG), 32'hC0);
        chk("rst AN", 32'(AN), 32'hFE);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst no_stale", dut.digit_q, 32'h0);
        chk("rst reload_busy", 32'(busy), 32'd1);
        count_high(n);
        chk("rst conv_len", 32'(n), 32'd34);
        chk("rst digits", dut.digit_q, 32'h00000042);
`ifdef LEADING_ZERO_BLANK_EN
        check_scan("lz42", 32'h00000042, 8'h03);
`else
        check_scan("lz42", 32'h00000042, 8'hFF);
`endif

        wait_idle();
        T_suc = 32'd0;
        wait_rise("zero");
        count_high(n);
        chk("zero digits", dut.digit_q, 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
        check_scan("zero", 32'h0, 8'h01);
`else
        check_scan("zero", 32'h0, 8'hFF);
`endif

        power = 1'b0;
        repeat (2) @(negedge clk);
        chk("power_off AN", 32'(AN), 32'hFF);
        chk("power_off SEG", 32'(SEG), 32'hFF);
        power = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        check_scan("power_on", 32'h0, 8'h01);
`else
        check_scan("power_on", 32'h0, 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
